multimode_timekeeper: RTL
=========================

Name: multimode_timekeeper

Overview:
- Single-clock-domain successor to the clock/stopwatch/timer top level.
- Generates its own tick enable from `clk`, so no divided clock is routed as a clock.
- Debounces all buttons internally. Runs time-of-day, stopwatch and countdown timer concurrently, and presents the selected function on registered HH:MM:SS outputs.
- Adds per-function FSMs, a timer reload register, a timer-done pulse, 12h PM flag and a clear button.

Parameters:
- CLK_HZ, 100000000, frequency of `clk` in Hz.
- TICK_HZ, 1, count rate in counted seconds per real second. Requires CLK_HZ divisible by TICK_HZ.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable `clk` cycles before a button change is accepted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mode_sel  in  2  00 stopwatch, 01 timer, 10 clock12, 11 clock24
- start_stop_btn  in  1  raw button
- clear_btn  in  1  raw button
- hour_btn  in  1  raw button
- min_btn  in  1  raw button
- sec_btn  in  1  raw button
- hour_out  out  5  selected hours
- min_out  out  6  selected minutes
- sec_out  out  6  selected seconds
- pm_out  out  1  PM flag; nonzero only in clock12 mode
- running  out  1  selected function is counting
- timer_done  out  1  one-cycle pulse on timer expiry

Behaviour:
- Reset:
  - Asynchronous, active-high. All counters are 00:00:00 and the prescaler is 0.
  - Clock FSM = RUN; stopwatch FSM = STOPPED; timer FSM = SET with reload register = 0.
  - All outputs are 0.
- Prescaler:
  - Free-running counter 0..CLK_HZ/TICK_HZ-1.
  - `tick` is a one-cycle pulse at terminal count. It is never reset by the FSMs.
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a stable-count debouncer, then a rising-edge detector.
  - The result is a one-cycle press pulse per debounced press.
  - Press pulses act only on the function selected by `mode_sel`. Non-selected functions keep counting in the background.
- Clock FSM (time-of-day, stored in 24h form, hours 0..23):
  - RUN: on `tick`, sec+1. 59 wraps to 0 and carries into min; min 59 wraps and carries into hour; hour 23 wraps to 0.
  - RUN + start_stop → SET. SET + start_stop → RUN.
  - In SET, `tick` is ignored. hour/min/sec presses increment their field mod 24/60/60 with no carry.
  - `clear` has no effect on the clock.
- Stopwatch FSM:
  - STOPPED ↔ RUNNING on start_stop.
  - RUNNING: counts up on `tick`. 23:59:59 wraps to 00:00:00.
  - `clear` zeroes the counter and forces STOPPED, in either state.
- Timer FSM (states SET, RUNNING, PAUSED, EXPIRED):
  - SET: hour/min/sec presses increment the field mod 24/60/60.
  - SET + start_stop:
    - If the value is 00:00:00, the press is ignored.
    - Otherwise copy the value to the reload register and go to RUNNING.
  - RUNNING: on `tick`, count down with borrow.
  - Decrementing to 00:00:00 → EXPIRED. `timer_done` pulses in the same cycle the counter becomes 0.
  - RUNNING ↔ PAUSED on start_stop.
  - EXPIRED + start_stop → SET with value = reload register.
  - `clear` in any state → SET with value 0 and reload register = 0.
- Simultaneous events:
  - `clear` beats start_stop in the same cycle.
  - start_stop beats `tick` in the same cycle (pause/stop is applied, that tick is discarded).
  - A field press and `tick` cannot conflict, because the FSMs accept presses only in non-counting states.
- 12h mapping (clock12 mode only):
  - hour24 0 → 12; 1..11 → unchanged; 12 → 12; 13..23 → hour24−12.
  - pm_out = (hour24 ≥ 12).
  - In all other modes pm_out = 0.
- Output registers:
  - hour_out/min_out/sec_out/pm_out/running are registered. Latency is one cycle from a counter or `mode_sel` change.
  - `running` = 1 for: clock RUN, stopwatch RUNNING, timer RUNNING.
- Reset asserted mid-operation returns everything to the reset state immediately (asynchronous), including any in-progress debounce.

Optional Feature:
- Macro: MULTIMODE_TIMEKEEPER_ALARM_EN.
- When defined, the block adds:
  - Inputs alarm_hour[4:0] and alarm_min[5:0].
  - Output alarm_out[0:0].
- alarm_out sets (sticky) on the cycle the clock in RUN transitions to hh:mm:00 with hh = alarm_hour and mm = alarm_min.
- alarm_out clears on a `clear` press while mode_sel is 10 or 11, or on reset.
- When undefined, these ports and this logic are absent.

Decomposition:
- Package `timekeeper_pkg` holds:
  - Mode encodings MODE_STOPWATCH=2'b00, MODE_TIMER=2'b01, MODE_CLK12=2'b10, MODE_CLK24=2'b11.
  - Timer state enum {T_SET, T_RUNNING, T_PAUSED, T_EXPIRED}.
  - Constants MAX_HOUR=23 and MAX_MINSEC=59.
- One sub-module, `button_conditioner` (synchroniser + debouncer + edge pulse, parameter DEBOUNCE_CYCLES), instantiated five times.

Test Plan:
All scenarios use CLK_HZ=20, TICK_HZ=1, DEBOUNCE_CYCLES=3.
- Clock set: mode 11, start_stop, 13 hour presses, start_stop, switch to mode 10 → hour_out=1, pm_out=1, min/sec=0, running=1.
- Rollover: set clock to 23:59:59, exit SET, one tick → 00:00:00. In mode 10 → hour_out=12, pm_out=0.
- Stopwatch: mode 00, start, 61 ticks → 00:01:01. Stop, 5 ticks → unchanged. Clear → 00:00:00, running=0.
- Timer: set 00:00:03, start, 3 ticks → 00:00:00 with timer_done high exactly one cycle. Next start_stop → SET showing 00:00:03. start_stop from SET at 00:00:00 → stays SET.
- Bounce: hour_btn high for 2 cycles only → no increment. Held 10 cycles → exactly one increment.
- Reset while timer RUNNING at 00:00:02 → outputs 0 asynchronously. After release, start_stop with no presses → still SET.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: mode encodings, timer states and HH:MM:SS arithmetic helpers.
package timekeeper_pkg;
  localparam logic [1:0] MODE_STOPWATCH = 2'b00;
  localparam logic [1:0] MODE_TIMER = 2'b01;
  localparam logic [1:0] MODE_CLK12 = 2'b10;
  localparam logic [1:0] MODE_CLK24 = 2'b11;
  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;
  typedef enum logic [1:0] {T_SET, T_RUNNING, T_PAUSED, T_EXPIRED} timer_state_t;
  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;
  function automatic logic [4:0] inc_h(input logic [4:0] h);
    return h == MAX_HOUR ? 5'd0 : h + 5'd1;
  endfunction
  function automatic logic [5:0] inc_ms(input logic [5:0] v);
    return v == MAX_MINSEC ? 6'd0 : v + 6'd1;
  endfunction
  function automatic logic [4:0] dec_h(input logic [4:0] h);
    return h == 5'd0 ? MAX_HOUR : h - 5'd1;
  endfunction
  function automatic logic [5:0] dec_ms(input logic [5:0] v);
    return v == 6'd0 ? MAX_MINSEC : v - 6'd1;
  endfunction
  function automatic hms_t inc_hms(input hms_t t);
    hms_t r;
    r = t;
    r.s = inc_ms(t.s);
    if (t.s == MAX_MINSEC) r.m = inc_ms(t.m);
    if (t.s == MAX_MINSEC && t.m == MAX_MINSEC) r.h = inc_h(t.h);
    return r;
  endfunction
  function automatic hms_t dec_hms(input hms_t t);
    hms_t r;
    r = t;
    r.s = dec_ms(t.s);
    if (t.s == 6'd0) r.m = dec_ms(t.m);
    if (t.s == 6'd0 && t.m == 6'd0) r.h = dec_h(t.h);
    return r;
  endfunction
  // Field presses while setting: each field wraps on its own, no carry.
  function automatic hms_t bump(input hms_t t, input logic hp, input logic mp, input logic sp);
    hms_t r;
    r = t;
    if (hp) r.h = inc_h(t.h);
    if (mp) r.m = inc_ms(t.m);
    if (sp) r.s = inc_ms(t.s);
    return r;
  endfunction
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    return h == 5'd0 ? 5'd12 : h > 5'd12 ? h - 5'd12 : h;
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF synchroniser, stable-count debouncer and rising-edge press pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] sync;
  logic stable, prev;
  logic [CW-1:0] cnt;
  // A change is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      stable <= 1'b0;
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      prev <= stable;
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign press = stable & ~prev;
endmodule

// File: rtl/multimode_timekeeper.sv
// multimode_timekeeper: concurrent time-of-day, stopwatch and countdown timer on one clock.
// Optional alarm (alarm_hour/alarm_min/alarm_out) enabled by MULTIMODE_TIMEKEEPER_ALARM_EN.
module multimode_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int TICK_HZ = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_sel,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  input  logic       hour_btn,
  input  logic       min_btn,
  input  logic       sec_btn,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       pm_out,
  output logic       running,
  output logic       timer_done
`ifdef MULTIMODE_TIMEKEEPER_ALARM_EN
  ,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic       alarm_out
`endif
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0] pre;
  logic tick;
  logic [4:0] raw, press;
  logic ss, clr, hp, mp, sp, sel_sw, sel_tm, sel_clk;
  hms_t clk_t, sw_t, tm_t, reload, disp;
  logic clk_set, sw_run, pm, run;
  logic [4:0] hr;
  timer_state_t tm_state;
  assign tick = pre == PW'(DIV - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  end
  assign raw = {sec_btn, min_btn, hour_btn, clear_btn, start_stop_btn};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(clk),
      .rst(reset),
      .raw(raw[i]),
      .press(press[i])
    );
  end
  assign {sp, mp, hp, clr, ss} = press;
  assign sel_sw = mode_sel == MODE_STOPWATCH;
  assign sel_tm = mode_sel == MODE_TIMER;
  assign sel_clk = mode_sel == MODE_CLK12 || mode_sel == MODE_CLK24;
  // Time of day: start_stop toggles RUN/SET and swallows a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_t <= '0;
      clk_set <= 1'b0;
    end else if (sel_clk && ss) clk_set <= !clk_set;
    else if (clk_set) clk_t <= bump(clk_t, sel_clk & hp, sel_clk & mp, sel_clk & sp);
    else if (tick) clk_t <= inc_hms(clk_t);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_t <= '0;
      sw_run <= 1'b0;
    end else if (sel_sw && clr) begin
      sw_t <= '0;
      sw_run <= 1'b0;
    end else if (sel_sw && ss) sw_run <= !sw_run;
    else if (sw_run && tick) sw_t <= inc_hms(sw_t);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tm_t <= '0;
      reload <= '0;
      tm_state <= T_SET;
      timer_done <= 1'b0;
    end else begin
      timer_done <= 1'b0;
      if (sel_tm && clr) begin
        tm_t <= '0;
        reload <= '0;
        tm_state <= T_SET;
      end else begin
        case (tm_state)
          T_SET:
            if (sel_tm && ss) begin
              if (tm_t != '0) begin
                reload <= tm_t;
                tm_state <= T_RUNNING;
              end
            end else tm_t <= bump(tm_t, sel_tm & hp, sel_tm & mp, sel_tm & sp);
          T_RUNNING:
            if (sel_tm && ss) tm_state <= T_PAUSED;
            else if (tick) begin
              tm_t <= dec_hms(tm_t);
              if (dec_hms(tm_t) == '0) begin
                tm_state <= T_EXPIRED;
                timer_done <= 1'b1;
              end
            end
          T_PAUSED: if (sel_tm && ss) tm_state <= T_RUNNING;
          default:
            if (sel_tm && ss) begin
              tm_t <= reload;
              tm_state <= T_SET;
            end
        endcase
      end
    end
  end
  always_comb begin
    disp = sel_sw ? sw_t : sel_tm ? tm_t : clk_t;
    hr = mode_sel == MODE_CLK12 ? to_12h(clk_t.h) : disp.h;
    pm = mode_sel == MODE_CLK12 && clk_t.h >= 5'd12;
    run = sel_sw ? sw_run : sel_tm ? tm_state == T_RUNNING : !clk_set;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_out <= '0;
      min_out <= '0;
      sec_out <= '0;
      pm_out <= 1'b0;
      running <= 1'b0;
    end else begin
      hour_out <= hr;
      min_out <= disp.m;
      sec_out <= disp.s;
      pm_out <= pm;
      running <= run;
    end
  end
`ifdef MULTIMODE_TIMEKEEPER_ALARM_EN
  hms_t nxt;
  assign nxt = inc_hms(clk_t);
  // Sticky until cleared from a clock mode; fires only on a real running-clock advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alarm_out <= 1'b0;
    else if (sel_clk && clr) alarm_out <= 1'b0;
    else if (!clk_set && tick && !(sel_clk && ss) && nxt.h == alarm_hour && nxt.m == alarm_min && nxt.s == 6'd0)
      alarm_out <= 1'b1;
  end
`endif
endmodule
